// File: rtl/mult_pkg.sv
// Shared constants, types and helpers for the shared-multiplier scheduler.
//   MULT_W      operand width
//   MULT_N_REQ  number of requesters
//   MULT_LAT    multiplier pipeline depth
//   req_id_t    requester index
//   prod_t      signed full-width product
//   rr_wrap     single-step modulo used by the round-robin search
package mult_pkg;

   localparam int MULT_W     = 8;
   localparam int MULT_N_REQ = 4;
   localparam int MULT_LAT   = 2;

   typedef logic [$clog2(MULT_N_REQ)-1:0] req_id_t;
   typedef logic signed [2*MULT_W-1:0]    prod_t;

   // Wraps an index that is known to be below 2*n back into 0..n-1
   // without a general divider.
   function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
      return (idx >= n) ? (idx - n) : idx;
   endfunction

endpackage

// File: rtl/mult_pipe.sv
// LAT-stage registered signed multiplier carrying a valid flag and a tag.
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset, clears every stage
//   en         advance the whole pipe by one stage
//   in_valid   operand pair present at the input
//   in_id      tag travelling with the operands
//   a, b       signed operands
//   out_valid  last stage holds a valid result
//   out_id     tag of the result in the last stage
//   out_p      signed full-width product in the last stage
//   any_valid  OR of every stage valid, output stage included
module mult_pipe #(
   parameter int LAT   = 2,
   parameter int WIDTH = 8,
   parameter int ID_W  = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     in_valid,
   input  logic [ID_W-1:0]          in_id,
   input  logic signed [WIDTH-1:0]  a,
   input  logic signed [WIDTH-1:0]  b,
   output logic                     out_valid,
   output logic [ID_W-1:0]          out_id,
   output logic signed [2*WIDTH-1:0] out_p,
   output logic                     any_valid
);

   logic                      r_vld_p0;
   logic [ID_W-1:0]           r_id_p0;
   logic signed [WIDTH-1:0]   r_a_p0;
   logic signed [WIDTH-1:0]   r_b_p0;
   logic signed [2*WIDTH-1:0] w_prod;

   // ---- stage 0: operand capture ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld_p0 <= 1'b0;
         r_id_p0  <= '0;
         r_a_p0   <= '0;
         r_b_p0   <= '0;
      end else if (en) begin
         r_vld_p0 <= in_valid;
         r_id_p0  <= in_id;
         r_a_p0   <= a;
         r_b_p0   <= b;
      end
   end

   // Operands are sign-extended first so the full 2*WIDTH product is kept,
   // including -2^(W-1) * -2^(W-1).
   assign w_prod = (2*WIDTH)'(r_a_p0) * (2*WIDTH)'(r_b_p0);

   if (LAT == 1) begin : g_lat1
      assign out_valid = r_vld_p0;
      assign out_id    = r_id_p0;
      assign out_p     = w_prod;
      assign any_valid = r_vld_p0;
   end else begin : g_latn
      logic                      r_vld_pn [1:LAT-1];
      logic [ID_W-1:0]           r_id_pn  [1:LAT-1];
      logic signed [2*WIDTH-1:0] r_p_pn   [1:LAT-1];

      // ---- stages 1..LAT-1: product register and delay line ----
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int k = 1; k < LAT; k++) begin
               r_vld_pn[k] <= 1'b0;
               r_id_pn[k]  <= '0;
               r_p_pn[k]   <= '0;
            end
         end else if (en) begin
            r_vld_pn[1] <= r_vld_p0;
            r_id_pn[1]  <= r_id_p0;
            r_p_pn[1]   <= w_prod;
            for (int k = 2; k < LAT; k++) begin
               r_vld_pn[k] <= r_vld_pn[k-1];
               r_id_pn[k]  <= r_id_pn[k-1];
               r_p_pn[k]   <= r_p_pn[k-1];
            end
         end
      end

      always_comb begin
         any_valid = r_vld_p0;
         for (int k = 1; k < LAT; k++) begin
            any_valid = any_valid | r_vld_pn[k];
         end
      end

      assign out_valid = r_vld_pn[LAT-1];
      assign out_id    = r_id_pn[LAT-1];
      assign out_p     = r_p_pn[LAT-1];
   end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one pipelined signed multiplier between
// N_REQ requesters; results return in issue order tagged with the requester.
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester operand pair present
//   req_ready  one-hot accept, combinational from req_valid
//   req_a/b    per-requester signed operands
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  consumer accepts the response
//   rsp_id     originating requester of the response
//   rsp_data   signed full-width product
//   busy       any pipeline stage holds a valid op
module mult_sched
   import mult_pkg::*;
#(
   parameter int N_REQ = MULT_N_REQ,
   parameter int WIDTH = MULT_W,
   parameter int LAT   = MULT_LAT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ-1:0][WIDTH-1:0]   req_a,
   input  logic [N_REQ-1:0][WIDTH-1:0]   req_b,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [$clog2(N_REQ)-1:0]      rsp_id,
   output logic signed [2*WIDTH-1:0]     rsp_data,
   output logic                          busy
);

   localparam int ID_W = $clog2(N_REQ);

   logic [ID_W-1:0] r_rr_ptr;
   logic [ID_W-1:0] w_cand;
   logic [ID_W-1:0] w_grant;
   logic            w_found;
   logic            w_adv;
   logic            w_issue;

   // The whole pipe moves unless a response is waiting and not taken.
   assign w_adv = !rsp_valid || rsp_ready;

   // First valid requester at or after the pointer, wrapping once.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_cand = ID_W'(rr_wrap(32'(r_rr_ptr) + 32'(k), N_REQ));
         if (!w_found && req_valid[w_cand]) begin
            w_found = 1'b1;
            w_grant = w_cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = (w_grant == ID_W'(i)) && req_valid[i] && w_found && w_adv && !rst;
      end
   end

   assign w_issue = |req_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr <= '0;
      end else if (w_issue) begin
         r_rr_ptr <= ID_W'(rr_wrap(32'(w_grant) + 32'd1, N_REQ));
      end
   end

   mult_pipe #(
      .LAT   (LAT),
      .WIDTH (WIDTH),
      .ID_W  (ID_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .en        (w_adv),
      .in_valid  (w_issue),
      .in_id     (w_grant),
      .a         ($signed(req_a[w_grant])),
      .b         ($signed(req_b[w_grant])),
      .out_valid (rsp_valid),
      .out_id    (rsp_id),
      .out_p     (rsp_data),
      .any_valid (busy)
   );

endmodule
